// File: rtl/slot_pkg.sv
// -----------------------------------------------------------------------------
// slot_pkg
// Shared types and defaults for the slot-game reel machinery.
//   state_t          : sequencer state encoding (IDLE/SPINUP/SPINNING/RESULT)
//   STATE_W          : width of the state encoding as seen on state_o
//   NUM_REELS_DEF    : default reel count shared by reel and scoring blocks
//   DELAY_CYCLES_DEF : default stagger between consecutive reel starts
// -----------------------------------------------------------------------------
package slot_pkg;

    localparam int STATE_W          = 2;
    localparam int NUM_REELS_DEF    = 3;
    localparam int DELAY_CYCLES_DEF = 7;

    // Encodings are visible on the debug port, so they are pinned explicitly.
    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        SPINUP   = 2'd1,
        SPINNING = 2'd2,
        RESULT   = 2'd3
    } state_t;

endpackage : slot_pkg

// File: rtl/slot_reel_sequencer_if.sv
// -----------------------------------------------------------------------------
// slot_reel_sequencer_if
// Button and reel-control bundle between the cabinet front end and the reel
// sequencer.
//   start_btn  : debounced single-cycle start request
//   stop_btn   : debounced single-cycle stop request, one bit per reel
//   reel_run   : 1 = reel i spinning (level)
//   reel_start : 1-cycle pulse in the cycle reel i begins spinning
//   busy       : 1 whenever the sequencer is not idle
//   game_done  : 1-cycle pulse once the last running reel has stopped
//   state_o    : current sequencer state, for display/debug
// master = button/front-end side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface slot_reel_sequencer_if
    import slot_pkg::*;
#(
    parameter int NUM_REELS = NUM_REELS_DEF
);

    logic                 start_btn;
    logic [NUM_REELS-1:0] stop_btn;
    logic [NUM_REELS-1:0] reel_run;
    logic [NUM_REELS-1:0] reel_start;
    logic                 busy;
    logic                 game_done;
    logic [STATE_W-1:0]   state_o;

    modport master (
        output start_btn,
        output stop_btn,
        input  reel_run,
        input  reel_start,
        input  busy,
        input  game_done,
        input  state_o
    );

    modport slave (
        input  start_btn,
        input  stop_btn,
        output reel_run,
        output reel_start,
        output busy,
        output game_done,
        output state_o
    );

endinterface : slot_reel_sequencer_if

// File: rtl/slot_stagger_timer.sv
// -----------------------------------------------------------------------------
// slot_stagger_timer
// Counts the gap between consecutive reel starts.
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-high
//   load    : set the count to 1 (a reel has just started)
//   tick_en : advance the count by one
//   expire  : count has reached DELAY_CYCLES (next reel is due this edge)
// When neither load nor tick_en is asserted the count returns to 0, so the
// counter rests at 0 whenever the sequencer is not staggering reel starts.
// -----------------------------------------------------------------------------
module slot_stagger_timer
    import slot_pkg::*;
#(
    parameter int DELAY_CYCLES = DELAY_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic tick_en,
    output logic expire
);

    localparam int            CW      = $clog2(DELAY_CYCLES + 1);
    localparam logic [CW-1:0] C_DELAY = CW'(DELAY_CYCLES);
    localparam logic [CW-1:0] C_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};

    logic [CW-1:0] r_count;

    // Stagger counter: load has priority so an expiring count restarts at 1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= C_ZERO;
        end else if (load) begin
            r_count <= C_ONE;
        end else if (tick_en) begin
            r_count <= r_count + C_ONE;
        end else begin
            r_count <= C_ZERO;
        end
    end

    // The count never passes DELAY_CYCLES: the owner reloads or clears on expiry.
    assign expire = (r_count == C_DELAY);

endmodule : slot_stagger_timer

// File: rtl/slot_reel_sequencer.sv
// -----------------------------------------------------------------------------
// slot_reel_sequencer
// Starts the reels one after another at a fixed stagger after a start press,
// stops them individually on their stop buttons and pulses game_done once the
// last reel has stopped. reel_run gates each reel's symbol counter.
//   clock : system clock, all state on rising edge
//   reset : asynchronous, active-high; clears all state immediately
//   bus   : slave side of slot_reel_sequencer_if (buttons in, reel control out)
// All bus outputs come straight from registers.
// -----------------------------------------------------------------------------
module slot_reel_sequencer
    import slot_pkg::*;
#(
    parameter int NUM_REELS    = NUM_REELS_DEF,
    parameter int DELAY_CYCLES = DELAY_CYCLES_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    slot_reel_sequencer_if.slave  bus
);

    localparam int                   IW       = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;
    localparam logic [IW-1:0]        IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0]        IDX_ONE  = IW'(1'b1);
    localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_REELS - 1);
    localparam logic [NUM_REELS-1:0] NO_REELS = {NUM_REELS{1'b0}};
    localparam logic [NUM_REELS-1:0] REEL0    = NUM_REELS'(1'b1);

    state_t               r_state;
    logic [NUM_REELS-1:0] r_reel_run;
    logic [NUM_REELS-1:0] r_reel_start;
    logic                 r_busy;
    logic                 r_game_done;
    logic                 r_done_sent;
    logic [IW-1:0]        r_idx;

    logic                 w_expire;
    logic                 w_timer_load;
    logic                 w_timer_tick;
    logic [NUM_REELS-1:0] w_idx_onehot;
    logic [NUM_REELS-1:0] w_run_after_stop;

    // Reel that starts next, and the run mask once this cycle's stops apply.
    assign w_idx_onehot     = REEL0 << r_idx;
    assign w_run_after_stop = r_reel_run & ~bus.stop_btn;

    // Timer control: load on every reel start except the last, count in between
    always_comb begin
        w_timer_load = 1'b0;
        w_timer_tick = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_load = bus.start_btn;
                w_timer_tick = 1'b0;
            end
            SPINUP: begin
                if (w_expire) begin
                    // Last reel: neither load nor tick, so the count clears.
                    w_timer_load = (r_idx != LAST_IDX);
                    w_timer_tick = 1'b0;
                end else begin
                    w_timer_load = 1'b0;
                    w_timer_tick = 1'b1;
                end
            end
            default: begin
                w_timer_load = 1'b0;
                w_timer_tick = 1'b0;
            end
        endcase
    end

    slot_stagger_timer #(
        .DELAY_CYCLES (DELAY_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (w_timer_load),
        .tick_en (w_timer_tick),
        .expire  (w_expire)
    );

    // Sequencer FSM: state, reel enables, start pulses and end-of-game pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_reel_run   <= NO_REELS;
            r_reel_start <= NO_REELS;
            r_busy       <= 1'b0;
            r_game_done  <= 1'b0;
            r_done_sent  <= 1'b0;
            r_idx        <= IDX_ZERO;
        end else begin
            // Pulses default low; only the branches below raise them.
            r_reel_start <= NO_REELS;
            r_game_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Stop buttons are meaningless with every reel parked.
                    if (bus.start_btn) begin
                        r_state      <= SPINUP;
                        r_busy       <= 1'b1;
                        r_reel_run   <= REEL0;
                        r_reel_start <= REEL0;
                        r_idx        <= IDX_ONE;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_idx   <= IDX_ZERO;
                    end
                end
                SPINUP: begin
                    // Buttons are ignored until every reel is up to speed.
                    r_busy <= 1'b1;
                    if (w_expire) begin
                        r_reel_run   <= r_reel_run | w_idx_onehot;
                        r_reel_start <= w_idx_onehot;
                        if (r_idx == LAST_IDX) begin
                            r_state <= SPINNING;
                            r_idx   <= IDX_ZERO;
                        end else begin
                            r_state <= SPINUP;
                            r_idx   <= r_idx + IDX_ONE;
                        end
                    end else begin
                        r_state <= SPINUP;
                    end
                end
                SPINNING: begin
                    // Stops on already-parked reels fall out of the AND mask.
                    r_busy     <= 1'b1;
                    r_reel_run <= w_run_after_stop;
                    if (w_run_after_stop == NO_REELS) begin
                        r_state <= RESULT;
                    end else begin
                        r_state <= SPINNING;
                    end
                end
                RESULT: begin
                    // First cycle raises game_done, second returns to IDLE;
                    // a start press here is dropped, not remembered.
                    if (!r_done_sent) begin
                        r_state     <= RESULT;
                        r_busy      <= 1'b1;
                        r_game_done <= 1'b1;
                        r_done_sent <= 1'b1;
                    end else begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_done_sent <= 1'b0;
                        r_idx       <= IDX_ZERO;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_reel_run  <= NO_REELS;
                    r_busy      <= 1'b0;
                    r_done_sent <= 1'b0;
                    r_idx       <= IDX_ZERO;
                end
            endcase
        end
    end

    assign bus.reel_run   = r_reel_run;
    assign bus.reel_start = r_reel_start;
    assign bus.busy       = r_busy;
    assign bus.game_done  = r_game_done;
    assign bus.state_o    = r_state;

endmodule : slot_reel_sequencer

// File: tb/tb_slot_reel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_slot_reel_sequencer
// Directed bench for slot_reel_sequencer. DUT A uses 3 reels with a 7-cycle
// stagger, DUT B uses 4 reels with a 1-cycle stagger. Expected output
// snapshots are queued with the edge they belong to and compared after that
// edge.
// -----------------------------------------------------------------------------
module tb_slot_reel_sequencer;

    typedef struct packed {
        logic [7:0] run;
        logic [7:0] start;
        logic       busy;
        logic       done;
        logic [1:0] state;
    } snap_t;

    typedef struct packed {
        int    edge_n;
        bit    dut_b;
        snap_t exp;
    } sb_t;

    logic  clock = 1'b0;
    logic  reset;
    int    edge_n  = 0;
    int    n_checks = 0;
    int    n_fail   = 0;
    sb_t   sb_q[$];
    string tag_q[$];

    slot_reel_sequencer_if #(.NUM_REELS(3)) bus_a ();
    slot_reel_sequencer_if #(.NUM_REELS(4)) bus_b ();

    slot_reel_sequencer #(.NUM_REELS(3), .DELAY_CYCLES(7)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    slot_reel_sequencer #(.NUM_REELS(4), .DELAY_CYCLES(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clock = ~clock;

    function automatic snap_t sample(bit b);
        snap_t s;
        if (b) begin
            s.run   = {4'b0000, bus_b.reel_run};
            s.start = {4'b0000, bus_b.reel_start};
            s.busy  = bus_b.busy;
            s.done  = bus_b.game_done;
            s.state = bus_b.state_o;
        end else begin
            s.run   = {5'b00000, bus_a.reel_run};
            s.start = {5'b00000, bus_a.reel_start};
            s.busy  = bus_a.busy;
            s.done  = bus_a.game_done;
            s.state = bus_a.state_o;
        end
        return s;
    endfunction

    task automatic check(string tag, snap_t obs, snap_t exp, int due);
        n_checks++;
        assert (obs === exp && due == edge_n) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h (edge %0d, due %0d)", tag, obs, exp, edge_n, due);
        end
    endtask

    task automatic expect_at(int e, bit b, string tag, logic [7:0] run, logic [7:0] st,
                             logic busy, logic done, logic [1:0] state);
        sb_t item;
        item.edge_n     = e;
        item.dut_b      = b;
        item.exp.run    = run;
        item.exp.start  = st;
        item.exp.busy   = busy;
        item.exp.done   = done;
        item.exp.state  = state;
        sb_q.push_back(item);
        tag_q.push_back(tag);
    endtask

    // Advance one edge, then compare every snapshot due at (or overdue by) it.
    task automatic step();
        sb_t   item;
        string tag;
        @(posedge clock);
        edge_n++;
        #1;
        while (sb_q.size() > 0 && sb_q[0].edge_n <= edge_n) begin
            item = sb_q.pop_front();
            tag  = tag_q.pop_front();
            check(tag, sample(item.dut_b), item.exp, item.edge_n);
        end
    endtask

    task automatic run_to(int target);
        while (edge_n < target) step();
    endtask

    initial begin
        snap_t zero_s;
        zero_s = '0;
        reset = 1'b1;
        bus_a.start_btn = 1'b0;
        bus_a.stop_btn  = 3'b000;
        bus_b.start_btn = 1'b0;
        bus_b.stop_btn  = 4'b0000;

        // Reset state on both instances
        expect_at(2, 1'b0, "a_reset_state", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        expect_at(2, 1'b1, "b_reset_state", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        run_to(2);
        reset = 1'b0;

        // Game 1: start sampled at edge 10, reels at 10/17/24
        run_to(9);
        bus_a.start_btn = 1'b1;
        expect_at(10, 1'b0, "g1_reel0_start", 8'h01, 8'h01, 1'b1, 1'b0, 2'd1);
        step();
        bus_a.start_btn = 1'b0;
        expect_at(11, 1'b0, "g1_spinup_hold", 8'h01, 8'h00, 1'b1, 1'b0, 2'd1);
        run_to(11);
        bus_a.stop_btn  = 3'b111;
        bus_a.start_btn = 1'b1;
        expect_at(12, 1'b0, "g1_spinup_ignores_buttons", 8'h01, 8'h00, 1'b1, 1'b0, 2'd1);
        step();
        bus_a.stop_btn  = 3'b000;
        bus_a.start_btn = 1'b0;
        expect_at(16, 1'b0, "g1_before_reel1", 8'h01, 8'h00, 1'b1, 1'b0, 2'd1);
        expect_at(17, 1'b0, "g1_reel1_start", 8'h03, 8'h02, 1'b1, 1'b0, 2'd1);
        expect_at(18, 1'b0, "g1_reel1_pulse_end", 8'h03, 8'h00, 1'b1, 1'b0, 2'd1);
        expect_at(23, 1'b0, "g1_before_reel2", 8'h03, 8'h00, 1'b1, 1'b0, 2'd1);
        expect_at(24, 1'b0, "g1_reel2_start_spinning", 8'h07, 8'h04, 1'b1, 1'b0, 2'd2);
        expect_at(25, 1'b0, "g1_spinning", 8'h07, 8'h00, 1'b1, 1'b0, 2'd2);
        run_to(29);
        bus_a.stop_btn = 3'b010;
        expect_at(30, 1'b0, "g1_stop_reel1", 8'h05, 8'h00, 1'b1, 1'b0, 2'd2);
        step();
        bus_a.stop_btn = 3'b000;
        run_to(31);
        bus_a.stop_btn = 3'b010;
        expect_at(32, 1'b0, "g1_stop_parked_reel", 8'h05, 8'h00, 1'b1, 1'b0, 2'd2);
        step();
        bus_a.stop_btn  = 3'b000;
        bus_a.start_btn = 1'b1;
        expect_at(33, 1'b0, "g1_spinning_ignores_start", 8'h05, 8'h00, 1'b1, 1'b0, 2'd2);
        step();
        bus_a.start_btn = 1'b0;
        run_to(34);
        bus_a.stop_btn = 3'b101;
        expect_at(35, 1'b0, "g1_last_stop_result", 8'h00, 8'h00, 1'b1, 1'b0, 2'd3);
        step();
        bus_a.stop_btn = 3'b000;

        // Start held high from RESULT onward: one game per IDLE visit
        bus_a.start_btn = 1'b1;
        expect_at(36, 1'b0, "g1_game_done", 8'h00, 8'h00, 1'b1, 1'b1, 2'd3);
        expect_at(37, 1'b0, "g1_back_to_idle", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        expect_at(38, 1'b0, "g2_start_first_idle_edge", 8'h01, 8'h01, 1'b1, 1'b0, 2'd1);
        expect_at(45, 1'b0, "g2_reel1_start", 8'h03, 8'h02, 1'b1, 1'b0, 2'd1);
        expect_at(52, 1'b0, "g2_reel2_start", 8'h07, 8'h04, 1'b1, 1'b0, 2'd2);
        run_to(54);
        bus_a.stop_btn = 3'b111;
        expect_at(55, 1'b0, "g2_stop_all", 8'h00, 8'h00, 1'b1, 1'b0, 2'd3);
        step();
        bus_a.stop_btn = 3'b000;
        expect_at(56, 1'b0, "g2_game_done", 8'h00, 8'h00, 1'b1, 1'b1, 2'd3);
        expect_at(57, 1'b0, "g2_back_to_idle", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        expect_at(58, 1'b0, "g3_held_start_taken", 8'h01, 8'h01, 1'b1, 1'b0, 2'd1);
        run_to(58);
        bus_a.start_btn = 1'b0;
        expect_at(65, 1'b0, "g3_reel1_start", 8'h03, 8'h02, 1'b1, 1'b0, 2'd1);
        expect_at(66, 1'b0, "g3_pre_reset", 8'h03, 8'h00, 1'b1, 1'b0, 2'd1);
        run_to(66);

        // Asynchronous reset mid-SPINUP: outputs clear without a clock edge
        #2;
        reset = 1'b1;
        #1;
        check("a_async_reset_midspin", sample(1'b0), zero_s, edge_n);
        check("b_async_reset", sample(1'b1), zero_s, edge_n);
        expect_at(67, 1'b0, "a_reset_held", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        step();
        reset = 1'b0;
        expect_at(68, 1'b0, "a_idle_after_reset", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        run_to(69);
        bus_a.start_btn = 1'b1;
        expect_at(70, 1'b0, "a_restart_after_reset", 8'h01, 8'h01, 1'b1, 1'b0, 2'd1);
        step();
        bus_a.start_btn = 1'b0;

        // DUT B: one-cycle stagger, four reels on consecutive edges
        run_to(79);
        bus_b.start_btn = 1'b1;
        expect_at(80, 1'b1, "b_reel0_start", 8'h01, 8'h01, 1'b1, 1'b0, 2'd1);
        step();
        bus_b.start_btn = 1'b0;
        expect_at(81, 1'b1, "b_reel1_start", 8'h03, 8'h02, 1'b1, 1'b0, 2'd1);
        expect_at(82, 1'b1, "b_reel2_start", 8'h07, 8'h04, 1'b1, 1'b0, 2'd1);
        expect_at(83, 1'b1, "b_reel3_start_spinning", 8'h0f, 8'h08, 1'b1, 1'b0, 2'd2);
        expect_at(84, 1'b1, "b_spinning", 8'h0f, 8'h00, 1'b1, 1'b0, 2'd2);
        run_to(85);
        bus_b.stop_btn = 4'b1111;
        expect_at(86, 1'b1, "b_stop_all", 8'h00, 8'h00, 1'b1, 1'b0, 2'd3);
        step();
        bus_b.stop_btn = 4'b0000;
        expect_at(87, 1'b1, "b_game_done", 8'h00, 8'h00, 1'b1, 1'b1, 2'd3);
        expect_at(88, 1'b1, "b_back_to_idle", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0);
        run_to(90);

        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drained: observed=%0d expected=0 entries left", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_slot_reel_sequencer

// File: doc/slot_reel_sequencer.md
Name: slot_reel_sequencer

Overview:
Top-level sequencer for the reel machinery of the slot game. It accepts a debounced start pulse and starts the reels one after another at a fixed stagger. It then accepts per-reel stop pulses and signals end-of-game when every reel has stopped. It drives the reel-run enables that gate each reel's symbol counter.

Parameters:
NUM_REELS, 3, number of reels; legal range 2..8
DELAY_CYCLES, 7, clock cycles between one reel's start and the next reel's start; legal range 1..255
CW, $clog2(DELAY_CYCLES+1), width of the stagger counter (derived, not overridable)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
start_btn  in  1  debounced single-cycle start request
stop_btn  in  NUM_REELS  debounced single-cycle stop request, one bit per reel
reel_run  out  NUM_REELS  1 = reel i spinning (level)
reel_start  out  NUM_REELS  1-cycle pulse in the cycle reel i begins spinning
busy  out  1  1 whenever state != IDLE
game_done  out  1  1-cycle pulse when the last running reel stops
state_o  out  2  current state encoding, for display/debug

Behaviour:
- Reset (asserted at any time, including mid-spin):
  - state=IDLE; reel_run, reel_start, busy, game_done = 0; stagger counter = 0; reel index = 0.
  - All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE=2'd0, SPINUP=2'd1, SPINNING=2'd2, RESULT=2'd3.
- IDLE:
  - start_btn=1 sampled at edge k → after edge k: state=SPINUP, reel_run[0]=1, reel_start[0]=1, counter=1, reel index=1.
  - stop_btn is ignored.
- SPINUP:
  - Counter increments each cycle.
  - When counter==DELAY_CYCLES at an edge: reel_run[idx]=1, reel_start[idx]=1, counter←1, idx←idx+1.
  - Reel i therefore starts at edge k + i*DELAY_CYCLES.
  - When the last reel (idx==NUM_REELS-1) starts, state←SPINNING on the same edge and the counter clears to 0.
  - start_btn and stop_btn are ignored in SPINUP.
  - DELAY_CYCLES=1 means the reels start on consecutive edges.
- SPINNING:
  - stop_btn[i]=1 with reel_run[i]=1 → reel_run[i]←0 at that edge.
  - Several stop bits in the same cycle are all honoured in that cycle.
  - A stop on an already-stopped reel is ignored.
  - start_btn is ignored.
  - If the edge leaves reel_run==0, state←RESULT.
- RESULT: game_done=1 for exactly one cycle, then state←IDLE unconditionally. start_btn in RESULT is ignored (not queued).
- reel_start is 0 in every cycle except the start cycles above. Its bits are one-hot or zero.
- busy = (state != IDLE), registered with the state.
- Unused state encodings are impossible here; if one is ever reached, recover to IDLE with outputs cleared.

Decomposition:
- Package slot_pkg:
  - state enum (IDLE/SPINUP/SPINNING/RESULT) and its 2-bit width;
  - NUM_REELS default constant, shared with the reel and scoring blocks.
- Sub-module slot_stagger_timer(clock, reset, load, tick_en, expire):
  - CW-bit counter; load sets the count to 1;
  - expire=1 when the count == DELAY_CYCLES.
  - The sequencer FSM owns idx and reel_run and instantiates one timer.

Test Plan:
- Reset mid-SPINUP (reel 0 and reel 1 running) → all outputs 0 on the same cycle; after release, state_o=0 and start_btn works again.
- NUM_REELS=3, DELAY_CYCLES=7, start pulse at edge 10 → reel_start[0] at edge 10, [1] at edge 17, [2] at edge 24; state_o=2 after edge 24; busy=1 from edge 10.
- During SPINUP, pulse stop_btn=3'b111 and start_btn → no effect; reel_run becomes 3'b111 exactly at edge 24.
- In SPINNING, stop 3'b010 at edge 30 → reel_run=3'b101; stop 3'b010 again → unchanged; stop 3'b101 together at edge 35 → reel_run=0, game_done=1 during the cycle after edge 36, state_o=0 after edge 37.
- start_btn held high continuously → exactly one game per IDLE visit; the next start is taken on the first IDLE edge after RESULT.
- DELAY_CYCLES=1, NUM_REELS=4 → reel_start pulses on four consecutive edges; SPINNING is entered on the fourth.
